irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Programmable interrupt controller between the peripheral IRQ sources (timer, input, output and future devices) and the CPU's 6-bit HWInt input.
- Synchronises the sources, latches them per source as edge- or level-triggered, and applies per-source mask and a global enable.
- Presents the highest-priority active source to the CPU as a registered one-hot HWInt.
- Sits on the bridge as a 4-word device: word address, write enable, write data, read data, in the same style as the timer.

Parameters:
NSRC, 6, number of interrupt sources (1..8); index 0 is the highest priority.
SYNC_STAGES, 2, synchroniser flops per source (>=2).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  reset, asynchronous and active-high.
add_i  in  2  register word select (bridge DEV_Addr[3:2]).
we_i  in  1  register write strobe, one cycle per write.
dat_i  in  32  write data.
dat_o  out  32  read data, combinational from add_i.
irq_src  in  NSRC  raw device interrupt lines, asynchronous.
hwint  out  6  one-hot highest-priority active source to the CPU; bits >= NSRC tie to 0.
irq_o  out  1  OR of hwint.

Behaviour:
Reset:
- CTRL, MASK, PEND, all synchroniser flops and the previous-sample flops clear to 0.
- hwint = 0, irq_o = 0.
- Reset asserted mid-operation discards all pending state immediately; no interrupt survives reset.

Register map (add_i):
- 0 CTRL (R/W): bit0 GEN (global enable); bits[8+NSRC-1:8] MODE, 1 = rising-edge, 0 = level; other bits read 0.
- 1 MASK (R/W): bits[NSRC-1:0], 1 = source enabled.
- 2 PEND: read returns pending bits. Write is W1C, but only on edge-mode bits; level-mode bits ignore the write.
- 3 ID: read returns bit31 = VALID, bits[2:0] = index of the highest-priority active source, other bits 0. Write is EOI: dat_i[2:0] names a source and clears its pending bit if it is in edge mode. An index >= NSRC or a level-mode source is a no-op.

Input path and pending bits:
- Synchroniser output s(i) is irq_src delayed by SYNC_STAGES clocks; p(i) is s(i) delayed one more clock.
- Edge mode: PEND(i) sets when s(i) & ~p(i). It stays set until a W1C or EOI clear.
- Level mode: PEND(i) is registered from s(i) every cycle and is not latched.

Latency (SYNC_STAGES = 2):
- irq_src rises before edge k; PEND is visible at k+2.
- hwint and irq_o are registered and assert at k+3.

Selection and output:
- active = PEND & MASK & {NSRC{GEN}}.
- Fixed priority, lowest index wins; the result is registered into hwint each cycle.
- The ID read uses the same combinational selection, so it may lead hwint by one cycle.
- MASK or GEN writes take effect on hwint the cycle after the write edge.

Simultaneous events and boundaries:
- Edge detected in the same cycle as a W1C or EOI clear of that bit: set wins, PEND stays 1.
- W1C and EOI never occur in the same cycle, because one write touches one address.
- MODE bit changed from level to edge: PEND(i) clears in that write cycle, so the next rising edge is required.
- MODE bit changed from edge to level: PEND(i) follows s(i) from the next cycle.
- Masked sources still latch PEND; unmasking an already-pending edge source raises hwint the next cycle.
- No active source: ID reads VALID = 0, bits[2:0] = 0; hwint = 0.
- Writes to read-only bits are ignored.

Decomposition:
- Shared package irq_ctrl_pkg: register word offsets (CTRL = 0, MASK = 1, PEND = 2, ID = 3), CTRL field positions (GEN bit 0, MODE base 8), ID VALID bit position 31, and a priority-encode function (one-hot and index).
- One natural sub-module, irq_sync_edge, instantiated once per source. It holds the SYNC_STAGES synchroniser plus previous-sample flop and outputs the synced level and a one-cycle rise pulse.
- The top holds the register file, pending logic and registered selection.

Test Plan:
1. Reset, write MASK = 0x3F, CTRL = 0x3F01 (all edge, GEN = 1). Pulse irq_src[2] for 1 cycle before edge k -> PEND = 0x04 at k+2; hwint = 0x04 and irq_o = 1 at k+3; ID reads 0x80000002. Write ID = 2 -> PEND = 0 and hwint = 0 one cycle later.
2. With the same setup, raise irq_src[4] and irq_src[1] together -> hwint = 0x02. EOI 1 -> hwint = 0x10. EOI 4 -> hwint = 0.
3. Level mode (CTRL = 0x0001, MASK = 0x01): hold irq_src[0] high -> hwint = 0x01. W1C PEND = 0x01 -> PEND stays 1. Drop the source -> hwint = 0 three cycles later.
4. Edge source 3 with MASK = 0x00 -> PEND = 0x08 and hwint = 0. Write MASK = 0x08 -> hwint = 0x08 the next cycle. Write CTRL GEN = 0 -> hwint = 0 the next cycle, PEND unchanged.
5. Time the rise-detect cycle of source 5 to coincide with a W1C write of PEND = 0x20 -> PEND[5] remains 1 and hwint = 0x20.
6. With PEND = 0x06 pending, assert rst asynchronously for less than one clock -> hwint, irq_o and dat_o (all registers) read 0 immediately. A held-high level source re-appears only after the full 3-cycle latency.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word offsets,
// CTRL/ID field positions and the fixed-priority encoder.
package irq_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_ID   = 2'd3;

    localparam int CTRL_GEN_BIT   = 0;
    localparam int CTRL_MODE_BASE = 8;
    localparam int ID_VALID_BIT   = 31;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic [7:0] onehot;
    } prio_t;

    // Scans from the top down so the lowest set index is the one left standing.
    function automatic prio_t prio_enc(input logic [7:0] vec);
        prio_t r;
        r = prio_t'(12'd0);
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid  = 1'b1;
                r.idx    = 3'(i);
                r.onehot = 8'd1 << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: multi-flop synchroniser, previous-sample
// flop and a one-cycle rising-edge pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    assign prev_d = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain and previous-sample flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: edge/level pending latches, per-source
// mask, global enable and a registered one-hot HWInt to the CPU.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      add_i,
    input  logic            we_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    input  logic [NSRC-1:0] irq_src,
    output logic [5:0]      hwint,
    output logic            irq_o
);

    logic            gen_q, gen_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [5:0]      hwint_q, hwint_d;
    logic            irq_q, irq_d;

    logic [NSRC-1:0] sync_s, rise_s, active_s, clr_s, to_edge_s;
    logic [7:0]      active_ext_s;
    prio_t           sel_s;
    logic            wr_ctrl_s, wr_mask_s, wr_pend_s, wr_id_s;
    logic            unused_s;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_src[g]),
            .sync_o (sync_s[g]),
            .rise_o (rise_s[g])
        );
    end

    assign wr_ctrl_s = we_i && (add_i == ADDR_CTRL);
    assign wr_mask_s = we_i && (add_i == ADDR_MASK);
    assign wr_pend_s = we_i && (add_i == ADDR_PEND);
    assign wr_id_s   = we_i && (add_i == ADDR_ID);

    assign gen_d  = wr_ctrl_s ? dat_i[CTRL_GEN_BIT] : gen_q;
    assign mode_d = wr_ctrl_s ? dat_i[CTRL_MODE_BASE +: NSRC] : mode_q;
    assign mask_d = wr_mask_s ? dat_i[NSRC-1:0] : mask_q;

    // Pending next state; a fresh edge outranks a same-cycle W1C/EOI clear.
    always_comb begin
        clr_s     = {NSRC{1'b0}};
        to_edge_s = {NSRC{1'b0}};
        pend_d    = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            clr_s[i] = mode_q[i] & ((wr_pend_s & dat_i[i]) |
                                    (wr_id_s & (dat_i[2:0] == 3'(i))));
            to_edge_s[i] = wr_ctrl_s & dat_i[CTRL_MODE_BASE + i] & ~mode_q[i];
            if (to_edge_s[i]) begin
                pend_d[i] = 1'b0;
            end else if (mode_q[i]) begin
                pend_d[i] = rise_s[i] | (pend_q[i] & ~clr_s[i]);
            end else begin
                pend_d[i] = sync_s[i];
            end
        end
    end

    // Combinational selection shared by the ID read and the HWInt register.
    always_comb begin
        active_s                  = pend_q & mask_q & {NSRC{gen_q}};
        active_ext_s              = 8'd0;
        active_ext_s[NSRC-1:0]    = active_s;
        sel_s                     = prio_enc(active_ext_s);
        hwint_d                   = sel_s.onehot[5:0];
        irq_d                     = |sel_s.onehot[5:0];
    end

    // Read-back mux; unlisted bits read as zero.
    always_comb begin
        dat_o = 32'd0;
        case (add_i)
            ADDR_CTRL: begin
                dat_o[CTRL_GEN_BIT]            = gen_q;
                dat_o[CTRL_MODE_BASE +: NSRC]  = mode_q;
            end
            ADDR_MASK: dat_o[NSRC-1:0] = mask_q;
            ADDR_PEND: dat_o[NSRC-1:0] = pend_q;
            ADDR_ID: begin
                dat_o[ID_VALID_BIT] = sel_s.valid;
                dat_o[2:0]          = sel_s.idx;
            end
            default: dat_o = 32'd0;
        endcase
    end

    // Register file, pending bits and registered CPU outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_q   <= 1'b0;
            mode_q  <= {NSRC{1'b0}};
            mask_q  <= {NSRC{1'b0}};
            pend_q  <= {NSRC{1'b0}};
            hwint_q <= 6'd0;
            irq_q   <= 1'b0;
        end else begin
            gen_q   <= gen_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            hwint_q <= hwint_d;
            irq_q   <= irq_d;
        end
    end

    assign hwint    = hwint_q;
    assign irq_o    = irq_q;
    assign unused_s = ^{dat_i, sel_s.onehot[7:6]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Scenario bench for irq_ctrl: expected values are queued when stimulus is
// applied and popped at each observation point.
`timescale 1ns/1ps
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  add_i = 2'd0;
    logic        we_i = 1'b0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic [5:0]  irq_src = 6'd0;
    logic [5:0]  hwint;
    logic        irq_o;
    logic [31:0] hw_obs;

    logic [31:0] sb[$];
    logic [31:0] exp_v;
    int          total = 0;
    int          bad = 0;

    irq_ctrl #(.NSRC(6), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .add_i(add_i), .we_i(we_i), .dat_i(dat_i),
        .dat_o(dat_o), .irq_src(irq_src), .hwint(hwint), .irq_o(irq_o)
    );

    always #10 clk = ~clk;
    assign hw_obs = {25'd0, irq_o, hwint};

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        add_i = a; dat_i = d; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0; dat_i = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        add_i = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) nxt();
        rst = 1'b0;
        for (int a = 0; a < 5; a++) sb.push_back(32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            exp_v = sb.pop_front(); total++;
            if (dat_o !== exp_v) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", a, dat_o, exp_v); end
        end
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL reset_hw got=%h exp=%h", hw_obs, exp_v); end
    endtask

    task automatic test_edge_basic();
        wr(ADDR_MASK, 32'h3F);
        wr(ADDR_CTRL, 32'h3F01);
        irq_src = 6'h04;
        sb.push_back(32'h04); sb.push_back(32'h00); sb.push_back(32'h8000_0002);
        sb.push_back(32'h44); sb.push_back(32'h8000_0002);
        sb.push_back(32'h00); sb.push_back(32'h44); sb.push_back(32'h00);
        nxt(); irq_src = 6'h00; nxt(); nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t1_pend_k2 got=%h exp=%h", dat_o, exp_v); end
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t1_hw_k2 got=%h exp=%h", hw_obs, exp_v); end
        rd(ADDR_ID); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t1_id_lead got=%h exp=%h", dat_o, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t1_hw_k3 got=%h exp=%h", hw_obs, exp_v); end
        rd(ADDR_ID); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t1_id got=%h exp=%h", dat_o, exp_v); end
        wr(ADDR_ID, 32'd2);
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t1_pend_eoi got=%h exp=%h", dat_o, exp_v); end
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t1_hw_eoi0 got=%h exp=%h", hw_obs, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t1_hw_eoi1 got=%h exp=%h", hw_obs, exp_v); end
    endtask

    task automatic test_priority();
        irq_src = 6'h12;
        sb.push_back(32'h42); sb.push_back(32'h8000_0001); sb.push_back(32'h42);
        sb.push_back(32'h50); sb.push_back(32'h00); sb.push_back(32'h0000_0000);
        repeat (4) nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t2_hw_both got=%h exp=%h", hw_obs, exp_v); end
        rd(ADDR_ID); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t2_id got=%h exp=%h", dat_o, exp_v); end
        wr(ADDR_ID, 32'd7);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t2_eoi_oob got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_ID, 32'd1);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t2_hw_eoi1 got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_ID, 32'd4);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t2_hw_eoi4 got=%h exp=%h", hw_obs, exp_v); end
        rd(ADDR_ID); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t2_id_none got=%h exp=%h", dat_o, exp_v); end
        irq_src = 6'h00;
        repeat (4) nxt();
    endtask

    task automatic test_level();
        wr(ADDR_CTRL, 32'h0001);
        wr(ADDR_MASK, 32'h01);
        irq_src = 6'h01;
        sb.push_back(32'h41); sb.push_back(32'h01); sb.push_back(32'h41); sb.push_back(32'h00);
        repeat (4) nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t3_hw_level got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_PEND, 32'h01);
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t3_w1c_ignored got=%h exp=%h", dat_o, exp_v); end
        irq_src = 6'h00;
        repeat (3) nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t3_hw_drop2 got=%h exp=%h", hw_obs, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t3_hw_drop3 got=%h exp=%h", hw_obs, exp_v); end
    endtask

    task automatic test_mask_gen();
        wr(ADDR_CTRL, 32'h3F01);
        wr(ADDR_MASK, 32'h00);
        irq_src = 6'h08;
        sb.push_back(32'h08); sb.push_back(32'h00); sb.push_back(32'h48);
        sb.push_back(32'h00); sb.push_back(32'h08); sb.push_back(32'h00);
        nxt(); irq_src = 6'h00; nxt(); nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t4_pend_masked got=%h exp=%h", dat_o, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t4_hw_masked got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_MASK, 32'h08);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t4_hw_unmask got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_CTRL, 32'h3F00);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t4_hw_gen0 got=%h exp=%h", hw_obs, exp_v); end
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t4_pend_gen0 got=%h exp=%h", dat_o, exp_v); end
        wr(ADDR_PEND, 32'h08);
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t4_pend_w1c got=%h exp=%h", dat_o, exp_v); end
    endtask

    task automatic test_set_wins();
        wr(ADDR_MASK, 32'h3F);
        wr(ADDR_CTRL, 32'h3F01);
        irq_src = 6'h20;
        sb.push_back(32'h20); sb.push_back(32'h60);
        nxt(); irq_src = 6'h00; nxt();
        wr(ADDR_PEND, 32'h20);
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t5_pend_setwins got=%h exp=%h", dat_o, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t5_hw_setwins got=%h exp=%h", hw_obs, exp_v); end
        wr(ADDR_PEND, 32'h20);
        repeat (2) nxt();
    endtask

    task automatic test_async_reset();
        wr(ADDR_CTRL, 32'h0601);
        irq_src = 6'h06;
        sb.push_back(32'h06); sb.push_back(32'h42); sb.push_back(32'h06);
        for (int a = 0; a < 5; a++) sb.push_back(32'd0);
        sb.push_back(32'h00); sb.push_back(32'h08); sb.push_back(32'h48);
        nxt(); irq_src = 6'h00; nxt(); nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t6_pend_pre got=%h exp=%h", dat_o, exp_v); end
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t6_hw_pre got=%h exp=%h", hw_obs, exp_v); end
        irq_src = 6'h08;
        nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t6_pend_hold got=%h exp=%h", dat_o, exp_v); end
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            exp_v = sb.pop_front(); total++;
            if (dat_o !== exp_v) begin bad++; $display("FAIL t6_rst_reg%0d got=%h exp=%h", a, dat_o, exp_v); end
        end
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t6_rst_hw got=%h exp=%h", hw_obs, exp_v); end
        rst = 1'b0;
        nxt(); nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t6_pend_e2 got=%h exp=%h", dat_o, exp_v); end
        nxt();
        rd(ADDR_PEND); exp_v = sb.pop_front(); total++;
        if (dat_o !== exp_v) begin bad++; $display("FAIL t6_pend_e3 got=%h exp=%h", dat_o, exp_v); end
        wr(ADDR_MASK, 32'h08);
        wr(ADDR_CTRL, 32'h0001);
        nxt();
        exp_v = sb.pop_front(); total++;
        if (hw_obs !== exp_v) begin bad++; $display("FAIL t6_hw_back got=%h exp=%h", hw_obs, exp_v); end
        irq_src = 6'h00;
        repeat (4) nxt();
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_level();
        test_mask_gen();
        test_set_wins();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
